// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single SDRAM command port between the latency-critical A-bus bridge and the
// Avalon master. It also schedules periodic auto-refresh. One transaction is in flight at a
// time. Priority is refresh, then A-bus, then Avalon. A starvation guard forces an Avalon win
// after STARVE_LIMIT back-to-back A-bus grants taken while Avalon was waiting.
//
// Ports
//   clk_i, rst_i               clock; synchronous active-high reset
//   abus_*_i / av_*_i          requester inputs: req, we, addr, wdata, be
//                              fields are held stable until the matching ack
//   abus_ack_o / av_ack_o      one-cycle completion pulse; rdata is valid in the same cycle
//   abus_rdata_o / av_rdata_o  last read data returned to that port
//   cmd_*_o                    command to the SDRAM engine
//                              cmd_refresh_o marks an auto-refresh command
//   cmd_ready_i                engine accepts the command (valid & ready)
//   cmd_done_i, cmd_rdata_i    completion pulse and read data from the engine
//   refresh_overrun_o          sticky flag: the interval expired with a refresh still pending
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W           = 25,
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned REFRESH_INTERVAL = 906,
  parameter int unsigned STARVE_LIMIT     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              abus_req_i,
  input  logic              abus_we_i,
  input  logic [ADDR_W-1:0] abus_addr_i,
  input  logic [DATA_W-1:0] abus_wdata_i,
  input  logic [1:0]        abus_be_i,
  output logic              abus_ack_o,
  output logic [DATA_W-1:0] abus_rdata_o,
  input  logic              av_req_i,
  input  logic              av_we_i,
  input  logic [ADDR_W-1:0] av_addr_i,
  input  logic [DATA_W-1:0] av_wdata_i,
  input  logic [1:0]        av_be_i,
  output logic              av_ack_o,
  output logic [DATA_W-1:0] av_rdata_o,
  output logic              cmd_valid_o,
  output logic              cmd_refresh_o,
  output logic              cmd_we_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_wdata_o,
  output logic [1:0]        cmd_be_o,
  input  logic              cmd_ready_i,
  input  logic              cmd_done_i,
  input  logic [DATA_W-1:0] cmd_rdata_i,
  output logic              refresh_overrun_o
);

  localparam int unsigned RefW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);
  localparam logic [RefW-1:0] RefReload = RefW'(REFRESH_INTERVAL - 1);
  localparam logic [StvW-1:0] StvMax    = StvW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;
  typedef enum logic [1:0] {GntNone, GntRefresh, GntAbus, GntAv} gnt_e;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d, arb_gnt;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              overrun_q, overrun_d;
  logic [StvW-1:0]   starve_q, starve_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_refresh_q, cmd_refresh_d;
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [1:0]        cmd_be_q, cmd_be_d;
  logic              abus_ack_q, abus_ack_d;
  logic              av_ack_q, av_ack_d;
  logic [DATA_W-1:0] abus_rdata_q, abus_rdata_d;
  logic [DATA_W-1:0] av_rdata_q, av_rdata_d;
  logic              ref_expire;
  logic              ref_accept;

  // Arbitration decision; only acted on in StIdle.
  always_comb begin
    arb_gnt = GntNone;
    if (ref_pend_q) begin
      arb_gnt = GntRefresh;
    end else if (av_req_i && (starve_q == StvMax)) begin
      arb_gnt = GntAv;
    end else if (abus_req_i) begin
      arb_gnt = GntAbus;
    end else if (av_req_i) begin
      arb_gnt = GntAv;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    starve_d      = starve_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_refresh_d = cmd_refresh_q;
    cmd_we_d      = cmd_we_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    cmd_be_d      = cmd_be_q;
    abus_ack_d    = 1'b0;
    av_ack_d      = 1'b0;
    abus_rdata_d  = abus_rdata_q;
    av_rdata_d    = av_rdata_q;
    ref_accept    = 1'b0;

    // Free-running refresh timer, independent of the transaction state.
    ref_expire = (ref_cnt_q == '0);
    ref_cnt_d  = ref_expire ? RefReload : ref_cnt_q - 1'b1;

    unique case (state_q)
      StIdle: begin
        if (arb_gnt != GntNone) begin
          gnt_d       = arb_gnt;
          cmd_valid_d = 1'b1;
          state_d     = StIssue;
        end
        unique case (arb_gnt)
          GntRefresh: begin
            cmd_refresh_d = 1'b1;
            cmd_we_d      = 1'b0;
            cmd_addr_d    = '0;
            cmd_wdata_d   = '0;
            cmd_be_d      = '0;
          end
          GntAbus: begin
            cmd_refresh_d = 1'b0;
            cmd_we_d      = abus_we_i;
            cmd_addr_d    = abus_addr_i;
            cmd_wdata_d   = abus_wdata_i;
            cmd_be_d      = abus_be_i;
            if (!av_req_i) begin
              starve_d = '0;
            end else if (starve_q != StvMax) begin
              starve_d = starve_q + 1'b1;
            end
          end
          GntAv: begin
            cmd_refresh_d = 1'b0;
            cmd_we_d      = av_we_i;
            cmd_addr_d    = av_addr_i;
            cmd_wdata_d   = av_wdata_i;
            cmd_be_d      = av_be_i;
            starve_d      = '0;
          end
          default: ;
        endcase
      end
      StIssue: begin
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          ref_accept  = cmd_refresh_q;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (cmd_done_i) begin
          if (gnt_q == GntRefresh) begin
            state_d = StIdle;
          end else begin
            state_d = StAck;
            if (gnt_q == GntAbus) begin
              abus_ack_d = 1'b1;
              if (!cmd_we_q) abus_rdata_d = cmd_rdata_i;
            end else begin
              av_ack_d = 1'b1;
              if (!cmd_we_q) av_rdata_d = cmd_rdata_i;
            end
          end
        end
      end
      StAck: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // An acceptance and an expiry in the same cycle leave the next refresh pending.
    ref_pend_d = (ref_pend_q & ~ref_accept) | ref_expire;
    overrun_d  = overrun_q | (ref_expire & ref_pend_q & ~ref_accept);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      gnt_q         <= GntNone;
      ref_cnt_q     <= RefReload;
      ref_pend_q    <= 1'b0;
      overrun_q     <= 1'b0;
      starve_q      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_we_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_be_q      <= '0;
      abus_ack_q    <= 1'b0;
      av_ack_q      <= 1'b0;
      abus_rdata_q  <= '0;
      av_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      overrun_q     <= overrun_d;
      starve_q      <= starve_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_refresh_q <= cmd_refresh_d;
      cmd_we_q      <= cmd_we_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      cmd_be_q      <= cmd_be_d;
      abus_ack_q    <= abus_ack_d;
      av_ack_q      <= av_ack_d;
      abus_rdata_q  <= abus_rdata_d;
      av_rdata_q    <= av_rdata_d;
    end
  end

  assign abus_ack_o        = abus_ack_q;
  assign abus_rdata_o      = abus_rdata_q;
  assign av_ack_o          = av_ack_q;
  assign av_rdata_o        = av_rdata_q;
  assign cmd_valid_o       = cmd_valid_q;
  assign cmd_refresh_o     = cmd_refresh_q;
  assign cmd_we_o          = cmd_we_q;
  assign cmd_addr_o        = cmd_addr_q;
  assign cmd_wdata_o       = cmd_wdata_q;
  assign cmd_be_o          = cmd_be_q;
  assign refresh_overrun_o = overrun_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter. It compares the DUT every cycle against a
// transaction-level reference model. The refresh timer is modelled as cycle-count arithmetic.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;
  localparam int unsigned RI = 40;
  localparam int unsigned SL = 8;

  localparam int PhIdle  = 0;
  localparam int PhIssue = 1;
  localparam int PhWait  = 2;
  localparam int PhAck   = 3;
  localparam int SrcNone = -1;
  localparam int SrcRef  = 0;
  localparam int SrcAbus = 1;
  localparam int SrcAv   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          abus_req, abus_we, av_req, av_we;
  logic [AW-1:0] abus_addr, av_addr;
  logic [DW-1:0] abus_wdata, av_wdata;
  logic [1:0]    abus_be, av_be;
  logic          abus_ack, av_ack;
  logic [DW-1:0] abus_rdata, av_rdata;
  logic          cmd_valid, cmd_refresh, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [1:0]    cmd_be;
  logic          cmd_ready, cmd_done;
  logic [DW-1:0] cmd_rdata;
  logic          refresh_overrun;

  sdram_port_arbiter #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .REFRESH_INTERVAL(RI),
    .STARVE_LIMIT    (SL)
  ) u_dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .abus_req_i       (abus_req),
    .abus_we_i        (abus_we),
    .abus_addr_i      (abus_addr),
    .abus_wdata_i     (abus_wdata),
    .abus_be_i        (abus_be),
    .abus_ack_o       (abus_ack),
    .abus_rdata_o     (abus_rdata),
    .av_req_i         (av_req),
    .av_we_i          (av_we),
    .av_addr_i        (av_addr),
    .av_wdata_i       (av_wdata),
    .av_be_i          (av_be),
    .av_ack_o         (av_ack),
    .av_rdata_o       (av_rdata),
    .cmd_valid_o      (cmd_valid),
    .cmd_refresh_o    (cmd_refresh),
    .cmd_we_o         (cmd_we),
    .cmd_addr_o       (cmd_addr),
    .cmd_wdata_o      (cmd_wdata),
    .cmd_be_o         (cmd_be),
    .cmd_ready_i      (cmd_ready),
    .cmd_done_i       (cmd_done),
    .cmd_rdata_i      (cmd_rdata),
    .refresh_overrun_o(refresh_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Stimulus controls
  bit force_rst   = 1'b1;
  bit saturate    = 1'b0;
  bit ready_block = 1'b0;
  bit rst_arm     = 1'b0;

  // Reference model: what the DUT should be showing in the current cycle
  int            m_phase;
  int            m_src;
  bit            m_pend, m_overrun, m_after_rst;
  int            m_starve;
  int            m_edge;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [1:0]    m_be;
  logic [DW-1:0] m_abus_rdata, m_av_rdata;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = PhIdle;
    m_src       = SrcNone;
    m_pend      = 1'b0;
    m_overrun   = 1'b0;
    m_starve    = 0;
    m_edge      = 0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wdata     = '0;
    m_be        = '0;
    m_abus_rdata = '0;
    m_av_rdata  = '0;
    m_after_rst = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit expire, ref_acc;
    int win;
    if (rst) begin
      model_reset();
      return;
    end
    m_after_rst = 1'b0;
    // The timer sits at RI-1 on the first edge after reset, so it reaches zero on edge RI-1.
    expire  = (m_edge % RI) == (RI - 1);
    m_edge++;
    ref_acc = 1'b0;
    case (m_phase)
      PhIdle: begin
        win = SrcNone;
        if (m_pend) win = SrcRef;
        else if (av_req && m_starve == SL) win = SrcAv;
        else if (abus_req) win = SrcAbus;
        else if (av_req) win = SrcAv;
        if (win == SrcAbus) begin
          m_starve = av_req ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
          {m_we, m_addr, m_wdata, m_be} = {abus_we, abus_addr, abus_wdata, abus_be};
        end else if (win == SrcAv) begin
          m_starve = 0;
          {m_we, m_addr, m_wdata, m_be} = {av_we, av_addr, av_wdata, av_be};
        end
        if (win != SrcNone) begin
          m_src   = win;
          m_phase = PhIssue;
        end
      end
      PhIssue: begin
        if (cmd_ready) begin
          m_phase = PhWait;
          ref_acc = (m_src == SrcRef);
        end
      end
      PhWait: begin
        if (cmd_done) begin
          if (m_src == SrcRef) begin
            m_phase = PhIdle;
          end else begin
            m_phase = PhAck;
            if (!m_we && m_src == SrcAbus) m_abus_rdata = cmd_rdata;
            if (!m_we && m_src == SrcAv) m_av_rdata = cmd_rdata;
          end
        end
      end
      default: m_phase = PhIdle;
    endcase
    if (expire && m_pend && !ref_acc) m_overrun = 1'b1;
    m_pend = (m_pend && !ref_acc) || expire;
  endtask

  task automatic check_outputs();
    check_eq("cmd_valid", cmd_valid, m_phase == PhIssue);
    check_eq("abus_ack", abus_ack, m_phase == PhAck && m_src == SrcAbus);
    check_eq("av_ack", av_ack, m_phase == PhAck && m_src == SrcAv);
    check_eq("abus_rdata", abus_rdata, m_abus_rdata);
    check_eq("av_rdata", av_rdata, m_av_rdata);
    check_eq("refresh_overrun", refresh_overrun, m_overrun);
    if (m_phase == PhIssue) check_eq("cmd_refresh", cmd_refresh, m_src == SrcRef);
    if (m_after_rst) check_eq("cmd_refresh_rst", cmd_refresh, 1'b0);
    if ((m_phase == PhIssue && m_src != SrcRef) || m_after_rst) begin
      check_eq("cmd_we", cmd_we, m_we);
      check_eq("cmd_addr", cmd_addr, m_addr);
      check_eq("cmd_wdata", cmd_wdata, m_wdata);
      check_eq("cmd_be", cmd_be, m_be);
    end
  endtask

  task automatic new_abus();
    abus_req   = 1'b1;
    abus_we    = 1'($urandom_range(0, 1));
    abus_addr  = AW'($urandom);
    abus_wdata = DW'($urandom);
    abus_be    = 2'($urandom_range(1, 3));
  endtask

  task automatic new_av();
    av_req   = 1'b1;
    av_we    = 1'($urandom_range(0, 1));
    av_addr  = AW'($urandom);
    av_wdata = DW'($urandom);
    av_be    = 2'($urandom_range(1, 3));
  endtask

  // Requesters follow the model's ack timing, so the stimulus never depends on DUT outputs.
  task automatic drive();
    rst = force_rst;
    if (m_phase == PhAck && m_src == SrcAbus) begin
      abus_req = 1'b0;
      if (saturate || $urandom_range(0, 1) == 0) new_abus();
    end else if (!abus_req && (saturate || $urandom_range(0, 3) == 0)) begin
      new_abus();
    end
    if (m_phase == PhAck && m_src == SrcAv) begin
      av_req = 1'b0;
      if (saturate || $urandom_range(0, 1) == 0) new_av();
    end else if (!av_req && (saturate || $urandom_range(0, 5) == 0)) begin
      new_av();
    end
    cmd_ready = ready_block ? 1'b0 : 1'($urandom_range(0, 1));
    cmd_done  = ($urandom_range(0, 2) == 0);
    cmd_rdata = DW'($urandom);
    if (rst_arm && m_phase == PhWait && m_src == SrcAbus && !m_we) begin
      rst     = 1'b1;
      rst_arm = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      drive();
      model_step();
    end
  endtask

  initial begin
    rst        = 1'b1;
    abus_req   = 1'b0;
    abus_we    = 1'b0;
    abus_addr  = '0;
    abus_wdata = '0;
    abus_be    = '0;
    av_req     = 1'b0;
    av_we      = 1'b0;
    av_addr    = '0;
    av_wdata   = '0;
    av_be      = '0;
    cmd_ready  = 1'b0;
    cmd_done   = 1'b0;
    cmd_rdata  = '0;
    model_reset();

    run(3);
    force_rst = 1'b0;
    run(800);
    // Both requesters always pending: exercises the starvation guard.
    saturate = 1'b1;
    run(600);
    saturate = 1'b0;
    // Reset landing while an A-bus read waits for the engine.
    rst_arm = 1'b1;
    run(600);
    rst_arm = 1'b0;
    // Engine stalls long enough for two expiries with a refresh still pending.
    ready_block = 1'b1;
    run(2 * RI + 10);
    ready_block = 1'b0;
    run(400);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
